// File: rtl/mac_pipe_pkg.sv
// Shared mode encodings and helpers for the pipelined dot-product MAC.
// Optional INT8/INT4 saturation is selected by MAC_PIPE_SAT_EN.
`ifndef INT8
`define INT8 0
`endif
`ifndef INT4
`define INT4 1
`endif
`ifndef INT4_VSQ
`define INT4_VSQ 2
`endif

package mac_pipe_pkg;

  localparam logic [1:0] MODE_INT8 = 2'(`INT8);
  localparam logic [1:0] MODE_INT4 = 2'(`INT4);
  localparam logic [1:0] MODE_VSQ  = 2'(`INT4_VSQ);

  function automatic int max_i(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mac_pipe_vec_product.sv
// vec_product: signed lane-wise multiply and sum of two flattened vectors.
// Lane width is BIT_WIDTH; OUT_W must hold the full-precision sum.
module vec_product #(
  parameter int BIT_WIDTH = 8,
  parameter int VEC_BITS  = 256,
  parameter int OUT_W     = 2 * BIT_WIDTH + $clog2(VEC_BITS / BIT_WIDTH)
) (
  input  logic [VEC_BITS-1:0] i_a,
  input  logic [VEC_BITS-1:0] i_b,
  output logic [OUT_W-1:0]    o_dot
);

  localparam int LANES = VEC_BITS / BIT_WIDTH;
  localparam int PW    = 2 * BIT_WIDTH;

  logic signed [BIT_WIDTH-1:0] la;
  logic signed [BIT_WIDTH-1:0] lb;
  logic signed [PW-1:0]        pr;

  always_comb begin
    o_dot = '0;
    la    = '0;
    lb    = '0;
    pr    = '0;
    for (int i = 0; i < LANES; i++) begin
      la    = i_a[i*BIT_WIDTH +: BIT_WIDTH];
      lb    = i_b[i*BIT_WIDTH +: BIT_WIDTH];
      pr    = la * lb;
      o_dot = o_dot + {{(OUT_W-PW){pr[PW-1]}}, pr};
    end
  end

endmodule

// File: rtl/mac_pipe.sv
// mac_pipe: 3-stage INT8/INT4/INT4_VSQ dot-product MAC with group accumulation.
// Define MAC_PIPE_SAT_EN to make INT8/INT4 saturate like VSQ instead of wrapping.
module mac_pipe
  import mac_pipe_pkg::*;
#(
  parameter int VEC_BITS = 256,
  parameter int ACC_W    = 24,
  parameter int SCALE_W  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [1:0]          i_mode,
  input  logic                i_first,
  input  logic                i_last,
  input  logic [ACC_W-1:0]    i_psum,
  input  logic [VEC_BITS-1:0] i_a,
  input  logic [VEC_BITS-1:0] i_b,
  input  logic [SCALE_W-1:0]  i_scale_a,
  input  logic [SCALE_W-1:0]  i_scale_b,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [ACC_W-1:0]    o_result,
  output logic                o_sat
);

  localparam int DOT8_W = 16 + $clog2(VEC_BITS / 8);
  localparam int DOT4_W = 8 + $clog2(VEC_BITS / 4);
  localparam int SF_W   = SCALE_W + 1;
  localparam int TERM_W = DOT4_W + SF_W + 1;
  localparam int EXT_W  = max_i(max_i(ACC_W, DOT8_W), TERM_W) + 1;
  localparam int SP_W   = 2 * SCALE_W + 1;

  // Extended-width sum; bit ACC_W of the return flags a clamp.
  function automatic logic [ACC_W:0] sat_add(
    input logic [EXT_W-1:0] x,
    input logic [EXT_W-1:0] y,
    input logic             clamp
  );
    logic signed [EXT_W-1:0] s;
    logic signed [EXT_W-1:0] mx;
    logic signed [EXT_W-1:0] mn;
    s  = x + y;
    mx = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    mn = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    if (clamp && (s > mx))
      return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    else if (clamp && (s < mn))
      return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
    else
      return {1'b0, s[ACC_W-1:0]};
  endfunction

  logic                en;
  logic [1:0]          eff_mode;
  logic [VEC_BITS-1:0] b8;
  logic [VEC_BITS-1:0] b4;
  logic [DOT8_W-1:0]   dot8;
  logic [DOT4_W-1:0]   dot4;

  logic                v1_q, v1_d;
  logic                first1_q, first1_d;
  logic                last1_q, last1_d;
  logic [1:0]          mode1_q, mode1_d;
  logic [1:0]          mode_q, mode_d;
  logic [DOT8_W-1:0]   dot8_q, dot8_d;
  logic [DOT4_W-1:0]   dot4_q, dot4_d;
  logic [SCALE_W-1:0]  sa_q, sa_d;
  logic [SCALE_W-1:0]  sb_q, sb_d;
  logic [ACC_W-1:0]    psum1_q, psum1_d;
  logic                v2_q, v2_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                gsat_q, gsat_d;
  logic                ov_q, ov_d;
  logic [ACC_W-1:0]    res_q, res_d;
  logic                sat_q, sat_d;

  logic [SP_W-1:0]          sp;
  logic [SF_W-1:0]          sf;
  logic signed [SF_W:0]     sf_s;
  logic signed [DOT4_W-1:0] dot4_s;
  logic signed [TERM_W-1:0] vsq;
  logic [EXT_W-1:0]         term_ext;
  logic [EXT_W-1:0]         base_ext;
  logic [ACC_W-1:0]         base;
  logic                     clamp_en;
  logic [ACC_W:0]           add_r;

  assign en       = i_ready | ~ov_q;
  assign o_ready  = en;
  assign o_valid  = ov_q;
  assign o_result = res_q;
  assign o_sat    = sat_q;

  assign eff_mode = i_first ? i_mode : mode_q;
  // Only the active lane engine sees b; the other multiplies by zero.
  assign b8 = (eff_mode == MODE_INT8) ? i_b : '0;
  assign b4 = (eff_mode == MODE_INT8) ? '0 : i_b;

  vec_product #(
    .BIT_WIDTH(8),
    .VEC_BITS (VEC_BITS),
    .OUT_W    (DOT8_W)
  ) u_vp8 (
    .i_a  (i_a),
    .i_b  (b8),
    .o_dot(dot8)
  );

  vec_product #(
    .BIT_WIDTH(4),
    .VEC_BITS (VEC_BITS),
    .OUT_W    (DOT4_W)
  ) u_vp4 (
    .i_a  (i_a),
    .i_b  (b4),
    .o_dot(dot4)
  );

  always_comb begin
    sp     = SP_W'(sa_q) * SP_W'(sb_q) + SP_W'(2 ** (SCALE_W - 1));
    sf     = SF_W'(sp >> SCALE_W);
    sf_s   = {1'b0, sf};
    dot4_s = dot4_q;
    vsq    = dot4_s * sf_s;
    term_ext = {{(EXT_W-DOT4_W){dot4_q[DOT4_W-1]}}, dot4_q};
    unique case (1'b1)
      (mode1_q == MODE_INT8):
        term_ext = {{(EXT_W-DOT8_W){dot8_q[DOT8_W-1]}}, dot8_q};
      (mode1_q == MODE_VSQ):
        term_ext = {{(EXT_W-TERM_W){vsq[TERM_W-1]}}, vsq};
      default:
        term_ext = {{(EXT_W-DOT4_W){dot4_q[DOT4_W-1]}}, dot4_q};
    endcase
`ifdef MAC_PIPE_SAT_EN
    clamp_en = 1'b1;
`else
    clamp_en = (mode1_q == MODE_VSQ);
`endif
    base     = first1_q ? psum1_q : acc_q;
    base_ext = {{(EXT_W-ACC_W){base[ACC_W-1]}}, base};
    add_r    = sat_add(base_ext, term_ext, clamp_en);
  end

  always_comb begin
    v1_d     = v1_q;
    first1_d = first1_q;
    last1_d  = last1_q;
    mode1_d  = mode1_q;
    mode_d   = mode_q;
    dot8_d   = dot8_q;
    dot4_d   = dot4_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    psum1_d  = psum1_q;
    v2_d     = v2_q;
    acc_d    = acc_q;
    gsat_d   = gsat_q;
    ov_d     = ov_q;
    res_d    = res_q;
    sat_d    = sat_q;
    if (en) begin
      v1_d = i_valid;
      if (i_valid) begin
        first1_d = i_first;
        last1_d  = i_last;
        mode1_d  = eff_mode;
        mode_d   = eff_mode;
        dot8_d   = dot8;
        dot4_d   = dot4;
        sa_d     = i_scale_a;
        sb_d     = i_scale_b;
        psum1_d  = i_psum;
      end
      v2_d = v1_q & last1_q;
      if (v1_q) begin
        acc_d  = add_r[ACC_W-1:0];
        gsat_d = (first1_q ? 1'b0 : gsat_q) | add_r[ACC_W];
      end
      ov_d = v2_q;
      if (v2_q) begin
        res_d = acc_q;
        sat_d = gsat_q;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      mode1_q  <= MODE_INT8;
      mode_q   <= MODE_INT8;
      dot8_q   <= '0;
      dot4_q   <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      psum1_q  <= '0;
      v2_q     <= 1'b0;
      acc_q    <= '0;
      gsat_q   <= 1'b0;
      ov_q     <= 1'b0;
      res_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      first1_q <= first1_d;
      last1_q  <= last1_d;
      mode1_q  <= mode1_d;
      mode_q   <= mode_d;
      dot8_q   <= dot8_d;
      dot4_q   <= dot4_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      psum1_q  <= psum1_d;
      v2_q     <= v2_d;
      acc_q    <= acc_d;
      gsat_q   <= gsat_d;
      ov_q     <= ov_d;
      res_q    <= res_d;
      sat_q    <= sat_d;
    end
  end

endmodule

// File: tb/tb_mac_pipe.sv
// Directed-vector bench for mac_pipe (VEC_BITS=256, ACC_W=24).
// Expected values honour MAC_PIPE_SAT_EN when it is defined.
module tb_mac_pipe;

  localparam logic [1:0] M8 = 2'd0;
  localparam logic [1:0] M4 = 2'd1;
  localparam logic [1:0] MV = 2'd2;

  typedef struct {
    logic [1:0]  m;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  sa;
    logic [7:0]  sb;
    logic [23:0] ps;
    logic [23:0] er;
    logic        es;
  } vec_t;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [1:0]   i_mode = M8;
  logic         i_first = 1'b0;
  logic         i_last = 1'b0;
  logic [23:0]  i_psum = '0;
  logic [255:0] i_a = '0;
  logic [255:0] i_b = '0;
  logic [7:0]   i_scale_a = '0;
  logic [7:0]   i_scale_b = '0;
  logic         o_valid;
  logic         i_ready = 1'b1;
  logic [23:0]  o_result;
  logic         o_sat;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b1;
  logic [23:0] rq[$];
  logic        sq[$];
  vec_t        tv[10];

  always #5 clk = ~clk;

  mac_pipe dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_mode   (i_mode),
    .i_first  (i_first),
    .i_last   (i_last),
    .i_psum   (i_psum),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_scale_a(i_scale_a),
    .i_scale_b(i_scale_b),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_sat    (o_sat)
  );

  always @(negedge clk) begin
    if (mon_en && o_valid && i_ready) begin
      rq.push_back(o_result);
      sq.push_back(o_sat);
    end
  end

  function automatic logic [255:0] rep(input logic [1:0] m, input logic [7:0] v);
    logic [255:0] r;
    r = '0;
    if (m == M8)
      for (int i = 0; i < 32; i++) r[i*8 +: 8] = v;
    else
      for (int i = 0; i < 64; i++) r[i*4 +: 4] = v[3:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] im, input logic [1:0] pm,
                       input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] sa, input logic [7:0] sb,
                       input logic [23:0] ps, input logic f, input logic l);
    @(negedge clk);
    i_valid   = 1'b1;
    i_mode    = im;
    i_a       = rep(pm, av);
    i_b       = rep(pm, bv);
    i_scale_a = sa;
    i_scale_b = sb;
    i_psum    = ps;
    i_first   = f;
    i_last    = l;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i_valid = 1'b0;
    end
    #1;
  endtask

  task automatic clr();
    rq.delete();
    sq.delete();
  endtask

  task automatic chk_q(input string nm, input int idx, input logic [23:0] er, input logic es);
    logic [23:0] r;
    logic        s;
    r = (rq.size() > idx) ? rq[idx] : 24'hxxxxxx;
    s = (sq.size() > idx) ? sq[idx] : 1'bx;
    chk({nm, "_res"}, 32'(r), 32'(er));
    chk({nm, "_sat"}, 32'(s), 32'(es));
  endtask

  initial begin
    int lat;
    int stall_err;
    logic [23:0] got[$];

    tv[0] = '{M8, 8'h01, 8'h02, 8'd0, 8'd0, 24'd10, 24'd74, 1'b0};
    tv[1] = '{M8, 8'hFF, 8'h03, 8'd0, 8'd0, 24'd0, 24'hFFFFA0, 1'b0};
    tv[2] = '{M4, 8'h01, 8'h01, 8'd0, 8'd0, 24'd0, 24'd64, 1'b0};
    tv[3] = '{M4, 8'h08, 8'h07, 8'd0, 8'd0, 24'd100, 24'hFFF264, 1'b0};
    tv[4] = '{MV, 8'h08, 8'h08, 8'd255, 8'd255, 24'h7F0000, 24'h7FFFFF, 1'b1};
    tv[5] = '{MV, 8'h01, 8'h01, 8'd128, 8'd128, 24'd0, 24'd4096, 1'b0};
    tv[6] = '{MV, 8'h08, 8'h07, 8'd255, 8'd255, 24'h800000, 24'h800000, 1'b1};
`ifdef MAC_PIPE_SAT_EN
    tv[7] = '{M8, 8'h7F, 8'h7F, 8'd0, 8'd0, 24'h7FFFFF, 24'h7FFFFF, 1'b1};
`else
    tv[7] = '{M8, 8'h7F, 8'h7F, 8'd0, 8'd0, 24'h7FFFFF, 24'h87E01F, 1'b0};
`endif
    tv[8] = '{M8, 8'h80, 8'h80, 8'd0, 8'd0, 24'd0, 24'h080000, 1'b0};
    tv[9] = '{MV, 8'h07, 8'h07, 8'd0, 8'd0, 24'd5, 24'd5, 1'b0};

    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_result", 32'(o_result), 0);
    chk("rst_sat", 32'(o_sat), 0);
    chk("rst_ready", 32'(o_ready), 1);

    for (int i = 0; i < 10; i++) begin
      clr();
      drive(tv[i].m, tv[i].m, tv[i].a, tv[i].b, tv[i].sa, tv[i].sb, tv[i].ps, 1'b1, 1'b1);
      lat = 0;
      while (rq.size() == 0 && lat < 10) begin
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        lat++;
      end
      chk($sformatf("vec%0d_lat", i), 32'(lat), 3);
      chk_q($sformatf("vec%0d", i), 0, tv[i].er, tv[i].es);
    end

    // INT4 group of 4 beats; non-first beats carry a bogus mode.
    clr();
    drive(M4, M4, 8'h01, 8'h01, 8'd0, 8'd0, 24'd0, 1'b1, 1'b0);
    drive(M8, M4, 8'h01, 8'h01, 8'd0, 8'd0, 24'd0, 1'b0, 1'b0);
    drive(M8, M4, 8'h01, 8'h01, 8'd0, 8'd0, 24'd0, 1'b0, 1'b0);
    drive(MV, M4, 8'h01, 8'h01, 8'd0, 8'd0, 24'd0, 1'b0, 1'b1);
    idle(8);
    chk("grp4_count", 32'(rq.size()), 1);
    chk_q("grp4", 0, 24'd256, 1'b0);

    // Back-to-back groups: sticky VSQ sat, sat cleared, continue from acc.
    clr();
    drive(MV, M4, 8'h08, 8'h08, 8'd255, 8'd255, 24'h7F0000, 1'b1, 1'b0);
    drive(M8, M4, 8'h01, 8'h0F, 8'd128, 8'd128, 24'd0, 1'b0, 1'b1);
    drive(M4, M4, 8'h01, 8'h01, 8'd0, 8'd0, 24'd3, 1'b1, 1'b1);
    drive(M8, M4, 8'h01, 8'h01, 8'd0, 8'd0, 24'd0, 1'b0, 1'b1);
    idle(8);
    chk("b2b_count", 32'(rq.size()), 3);
    chk_q("b2b_a", 0, 24'h7FEFFF, 1'b1);
    chk_q("b2b_b", 1, 24'd67, 1'b0);
    chk_q("b2b_c", 2, 24'd131, 1'b0);

    // Backpressure: three single-shot groups, downstream stalled 5 cycles.
    @(negedge clk);
    #1;
    mon_en  = 1'b0;
    i_ready = 1'b0;
    drive(M8, M8, 8'h01, 8'h01, 8'd0, 8'd0, 24'd0, 1'b1, 1'b1);
    drive(M8, M8, 8'h01, 8'h02, 8'd0, 8'd0, 24'd0, 1'b1, 1'b1);
    drive(M8, M8, 8'h01, 8'h03, 8'd0, 8'd0, 24'd0, 1'b1, 1'b1);
    stall_err = 0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      i_valid = 1'b0;
      #1;
      if (!(o_valid && !o_ready && o_result == 24'd32)) stall_err++;
    end
    chk("bp_stall", 32'(stall_err), 0);
    i_ready = 1'b1;
    if (o_valid) got.push_back(o_result);
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      #1;
      if (o_valid) got.push_back(o_result);
    end
    chk("bp_count", 32'(got.size()), 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp_res%0d", k),
          (got.size() > k) ? 32'(got[k]) : 32'hFFFF_FFFF, 32'((k + 1) * 32));
    mon_en = 1'b1;

    // Reset after beat 2 of a 4-beat group.
    clr();
    drive(M8, M8, 8'h01, 8'h01, 8'd0, 8'd0, 24'd1000, 1'b1, 1'b0);
    drive(M8, M8, 8'h01, 8'h01, 8'd0, 8'd0, 24'd0, 1'b0, 1'b0);
    @(negedge clk);
    i_valid = 1'b0;
    i_rst   = 1'b1;
    #1;
    chk("mrst_valid", 32'(o_valid), 0);
    chk("mrst_result", 32'(o_result), 0);
    chk("mrst_sat", 32'(o_sat), 0);
    #1;
    i_rst = 1'b0;
    #1;
    chk("mrst_ready", 32'(o_ready), 1);
    idle(5);
    chk("mrst_dropped", 32'(rq.size()), 0);
    drive(M4, M8, 8'h01, 8'h01, 8'd0, 8'd0, 24'd0, 1'b0, 1'b1);
    drive(M4, M4, 8'h01, 8'h01, 8'd0, 8'd0, 24'd7, 1'b1, 1'b1);
    idle(8);
    chk("mrst_count", 32'(rq.size()), 2);
    chk_q("mrst_acc0", 0, 24'd32, 1'b0);
    chk_q("mrst_seed", 1, 24'd71, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
